// File: rtl/mips_pkg.sv
// Purpose: shared types and constants for the MIPS execute stage and its mult/div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int MD_ITER = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MULT,
        ALU_MULTU,
        ALU_DIV,
        ALU_DIVU,
        ALU_MFHI,
        ALU_MFLO
    } alu_op_t;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    // True for the operations handled by the iterative HI/LO unit.
    function automatic logic is_muldiv(input alu_op_t op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Purpose: iterative shift-add multiplier / restoring divider on magnitudes, owning HI/LO.
// Latency: MD_ITER cycles from the start edge; HI/LO update on the final busy edge.
// Backpressure: busy is high for the whole operation; start is ignored while busy.
module mul_div_unit #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int MD_ITER = mips_pkg::MD_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    import mips_pkg::*;

    localparam int CW = $clog2(MD_ITER);

    md_state_t           state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc, acc_nxt, prod;
    logic [DATA_W-1:0]   bmag, amag, bmag_in, q_fix, r_fix;
    logic [DATA_W:0]     add_sum, rem_sh, trial;
    logic                is_div, neg_q, neg_r, b_zero;
    logic                sgn_op, a_neg, b_neg, last;
    alu_op_t             op_e;

    assign op_e    = alu_op_t'(op);
    assign sgn_op  = (op_e == ALU_MULT) || (op_e == ALU_DIV);
    assign a_neg   = sgn_op & a[DATA_W-1];
    assign b_neg   = sgn_op & b[DATA_W-1];
    assign amag    = a_neg ? -a : a;
    assign bmag_in = b_neg ? -b : b;
    assign busy    = (state == MD_BUSY);
    assign last    = busy && (cnt == CW'(MD_ITER - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    // Next state: leave IDLE on start, return after the final iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: if (last)  state_nxt = MD_IDLE;
            default:            state_nxt = MD_IDLE;
        endcase
    end

    // One iteration step plus the sign-corrected results used on the final edge.
    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, bmag} : '0);
        rem_sh  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        trial   = rem_sh - {1'b0, bmag};
        if (is_div) begin
            if (trial[DATA_W]) acc_nxt = {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            else               acc_nxt = {trial[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
        end else begin
            acc_nxt = {add_sum, acc[DATA_W-1:1]};
        end
        prod  = neg_q ? -acc_nxt : acc_nxt;
        q_fix = b_zero ? '1 : (neg_q ? -acc_nxt[DATA_W-1:0] : acc_nxt[DATA_W-1:0]);
        r_fix = neg_r ? -acc_nxt[2*DATA_W-1:DATA_W] : acc_nxt[2*DATA_W-1:DATA_W];
    end

    // Datapath: load magnitudes and sign flags on start, iterate while busy, commit HI/LO last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            bmag   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == MD_IDLE) begin
            if (start) begin
                cnt    <= '0;
                acc    <= {{DATA_W{1'b0}}, amag};
                bmag   <= bmag_in;
                is_div <= (op_e == ALU_DIV) || (op_e == ALU_DIVU);
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (b == '0);
            end
        end else begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            if (last) begin
                if (is_div) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    hi <= prod[2*DATA_W-1:DATA_W];
                    lo <= prod[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Purpose: MIPS execute stage: operand/destination muxes, ALU, HI/LO unit and EX/MEM register.
// Latency: 1 cycle for ALU ops; mult/div occupy the HI/LO unit for MD_ITER further cycles.
// Backpressure: stall_out holds ID/EX while the HI/LO unit is busy; bubbles are emitted meanwhile.
module execute_stage #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int REG_AW  = mips_pkg::REG_AW,
    parameter int MD_ITER = mips_pkg::MD_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic [3:0]        ALUControl,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    input  logic [DATA_W-1:0] SignImm,
    input  logic [REG_AW-1:0] Rt,
    input  logic [REG_AW-1:0] Rd,
    output logic              stall_out,
    output logic              valid_out,
    output logic              RegWriteOut,
    output logic              MemtoRegOut,
    output logic              MemWriteOut,
    output logic [REG_AW-1:0] WriteRegOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] WriteDataOut
);
    import mips_pkg::*;

    alu_op_t           op;
    logic [DATA_W-1:0] src_b, alu_res, hi, lo;
    logic [4:0]        shamt;
    logic              accept, md_op, md_busy;

    assign op        = alu_op_t'(ALUControl);
    assign src_b     = ALUSrc ? SignImm : RD2;
    assign shamt     = SignImm[10:6];
    assign md_op     = is_muldiv(op);
    assign stall_out = md_busy;
    assign accept    = in_valid & ~stall_out;

    mul_div_unit #(
        .DATA_W  (DATA_W),
        .MD_ITER (MD_ITER)
    ) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (accept & md_op),
        .op    (ALUControl),
        .a     (RD1),
        .b     (src_b),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Single-cycle ALU; mult/div produce no ALU result of their own.
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = RD1 + src_b;
            ALU_SUB:  alu_res = RD1 - src_b;
            ALU_AND:  alu_res = RD1 & src_b;
            ALU_OR:   alu_res = RD1 | src_b;
            ALU_XOR:  alu_res = RD1 ^ src_b;
            ALU_NOR:  alu_res = ~(RD1 | src_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(RD1) < $signed(src_b)};
            ALU_SLL:  alu_res = RD2 << shamt;
            ALU_SRL:  alu_res = RD2 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(RD2) >>> shamt);
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // EX/MEM register: load on accept, otherwise insert a bubble by clearing the controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out    <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemtoRegOut  <= 1'b0;
            MemWriteOut  <= 1'b0;
            WriteRegOut  <= '0;
            ALUResultOut <= '0;
            WriteDataOut <= '0;
        end else if (accept) begin
            valid_out    <= 1'b1;
            RegWriteOut  <= RegWrite & ~md_op;
            MemtoRegOut  <= MemtoReg;
            MemWriteOut  <= MemWrite;
            WriteRegOut  <= RegDst ? Rd : Rt;
            ALUResultOut <= alu_res;
            WriteDataOut <= RD2;
        end else begin
            valid_out    <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemtoRegOut  <= 1'b0;
            MemWriteOut  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Purpose: scoreboard bench for execute_stage using directed vectors with hand-computed results.
// Latency: expects each accepted instruction on EX/MEM one edge after acceptance.
// Backpressure: stimulus holds instructions while stall_out is high.
module tb_execute_stage;
    import mips_pkg::*;

    logic        clk, rst, in_valid, RegWrite, MemtoReg, MemWrite, RegDst, ALUSrc;
    logic [3:0]  ALUControl;
    logic [31:0] RD1, RD2, SignImm;
    logic [4:0]  Rt, Rd;
    logic        stall_out, valid_out, RegWriteOut, MemtoRegOut, MemWriteOut;
    logic [4:0]  WriteRegOut;
    logic [31:0] ALUResultOut, WriteDataOut;

    typedef struct packed {
        logic        rw, m2r, mw;
        logic [4:0]  wreg;
        logic [31:0] res, wdat;
        logic        chk_res;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .RD1(RD1), .RD2(RD2), .SignImm(SignImm), .Rt(Rt), .Rd(Rd), .stall_out(stall_out),
        .valid_out(valid_out), .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut),
        .MemWriteOut(MemWriteOut), .WriteRegOut(WriteRegOut), .ALUResultOut(ALUResultOut),
        .WriteDataOut(WriteDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every valid EX/MEM output against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && valid_out) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid_out", 32'(valid_out), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("ctl#%0d", popped),
                          {24'b0, RegWriteOut, MemtoRegOut, MemWriteOut, WriteRegOut},
                          {24'b0, e.rw, e.m2r, e.mw, e.wreg});
                    if (e.chk_res) check($sformatf("result#%0d", popped), ALUResultOut, e.res);
                    check($sformatf("wdata#%0d", popped), WriteDataOut, e.wdat);
                    popped++;
                end
            end
        end
    end

    // Drive one instruction, hold it while stalled, and queue its expected EX/MEM image.
    task automatic send(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic asrc, input logic rdst,
                        input logic rw, input logic m2r, input logic mw,
                        input logic [4:0] rt_i, input logic [4:0] rd_i,
                        input logic [31:0] exp_res, input logic chk);
        exp_t e;
        int   n;
        @(negedge clk);
        ALUControl = op; RD1 = a; RD2 = b; SignImm = imm; ALUSrc = asrc; RegDst = rdst;
        RegWrite = rw; MemtoReg = m2r; MemWrite = mw; Rt = rt_i; Rd = rd_i; in_valid = 1'b1;
        n = 0;
        while (stall_out && n < 200) begin
            check("held_memwrite", 32'(MemWriteOut), 32'd0);
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("stall_timeout", 32'(n), 32'd0);
        e.rw      = rw & ~(op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU});
        e.m2r     = m2r;
        e.mw      = mw;
        e.wreg    = rdst ? rd_i : rt_i;
        e.res     = exp_res;
        e.wdat    = b;
        e.chk_res = chk;
        sbq.push_back(e);
    endtask

    task automatic rtype(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd_i, input logic [31:0] exp_res);
        send(op, a, b, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, rd_i, exp_res, 1'b1);
    endtask

    task automatic shift(input alu_op_t op, input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_res);
        send(op, 32'd0, b, {21'b0, sh, 6'b0}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd12,
             exp_res, 1'b1);
    endtask

    task automatic md(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        send(op, a, b, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int stall_cnt, bub, n;
        rst = 1'b0; in_valid = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; MemWrite = 1'b0;
        RegDst = 1'b0; ALUSrc = 1'b0; ALUControl = 4'd0; RD1 = '0; RD2 = '0; SignImm = '0;
        Rt = '0; Rd = '0;
        #1;
        check("rst_outputs", {ALUResultOut | WriteDataOut}, 32'd0);
        check("rst_ctl", {22'b0, stall_out, valid_out, RegWriteOut, MemtoRegOut, MemWriteOut,
                          WriteRegOut}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic ALU and boundary cases.
        send(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd9, 32'd12, 1'b1);
        rtype(ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd4, 32'd1);
        rtype(ALU_SLT, 32'd1, 32'hFFFFFFFF, 5'd4, 32'd0);
        shift(ALU_SRA, 32'h80000000, 5'd4, 32'hF8000000);
        shift(ALU_SRL, 32'h80000000, 5'd4, 32'h08000000);
        shift(ALU_SLL, 32'd1, 5'd31, 32'h80000000);
        rtype(ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd5, 32'h80000000);
        rtype(ALU_SUB, 32'd3, 32'd5, 5'd6, 32'hFFFFFFFE);
        rtype(ALU_AND, 32'h0000F0F0, 32'h0000FF00, 5'd7, 32'h0000F000);
        rtype(ALU_OR,  32'h0000F0F0, 32'h0000FF00, 5'd7, 32'h0000FFF0);
        rtype(ALU_XOR, 32'h0000F0F0, 32'h0000FF00, 5'd7, 32'h00000FF0);
        rtype(ALU_NOR, 32'd0, 32'd0, 5'd8, 32'hFFFFFFFF);
        // addi (immediate operand, dest = Rt) and a load (MemtoReg pass-through).
        send(ALU_ADD, 32'd10, 32'h55, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd9, 32'd9, 1'b1);
        send(ALU_ADD, 32'd64, 32'h11, 32'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 5'd9, 32'd68, 1'b1);

        // MULT -3 x 7: measure the stall window and the bubbles it produces.
        md(ALU_MULT, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        stall_cnt = 0; bub = 0; n = 0;
        while (stall_out && n < 100) begin
            stall_cnt++;
            @(negedge clk);
            if (!valid_out) bub++;
            n++;
        end
        check("mult_stall_cycles", 32'(stall_cnt), 32'd32);
        check("mult_bubbles", 32'(bub), 32'd32);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'hFFFFFFEB);
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'hFFFFFFFF);

        md(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'hFFFFFFFE);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'h00000001);
        md(ALU_DIVU, 32'd100, 32'd7);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'd14);
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'd2);
        md(ALU_DIV, 32'hFFFFFFF9, 32'd2);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'hFFFFFFFD);
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'hFFFFFFFF);
        md(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'h80000000);
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'd0);
        md(ALU_DIV, 32'd5, 32'd0);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'hFFFFFFFF);
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'd5);

        // Asynchronous reset in the middle of a MULT.
        md(ALU_MULT, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        check("busy_before_rst", 32'(stall_out), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ctl", {22'b0, stall_out, valid_out, RegWriteOut, MemtoRegOut, MemWriteOut,
                             WriteRegOut}, 32'd0);
        check("midrst_data", ALUResultOut | WriteDataOut, 32'd0);
        check("midrst_hi", dut.u_md.hi, 32'd0);
        check("midrst_lo", dut.u_md.lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rtype(ALU_MFHI, 32'd0, 32'd0, 5'd11, 32'd0);
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'd0);

        // Idle input produces bubbles; a store held behind a MULT emits exactly once.
        idle_cycle();
        @(negedge clk);
        check("idle_valid", 32'(valid_out), 32'd0);
        check("idle_memwrite", 32'(MemWriteOut), 32'd0);
        md(ALU_MULT, 32'd2, 32'd3);
        send(ALU_ADD, 32'd100, 32'hCAFE, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 32'd108, 1'b1);
        idle_cycle();
        rtype(ALU_MFLO, 32'd0, 32'd0, 5'd10, 32'd6);
        idle_cycle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a hung DUT still ends the run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
